sprite_loader: RTL

SPRITE_LOADER -- requirements
Module: sprite_loader

---
 rtl/sprite_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/sprite_loader.sv
// Streams RGB444 pixels from a valid/ready source into a sprite BRAM write port,
// one write per accepted beat, starting at a latched base address.
module sprite_loader #(
  parameter int ram_add_width = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ram_add_width-1:0] base_addr,
  input  logic [ram_add_width-1:0] length,
  input  logic                     abort,
  input  logic                     s_valid,
  input  logic [11:0]              s_data,
  output logic                     s_ready,
  output logic [ram_add_width-1:0] wr_add,
  output logic [11:0]              wr_data,
  output logic                     wr_req,
  output logic                     busy,
  output logic                     done,
  output logic [ram_add_width-1:0] count
);

  localparam int AW = ram_add_width;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [AW-1:0]   base_r;
  logic [AW-1:0]   len_r;
  logic [AW-1:0]   count_r;
  logic [AW-1:0]   count_inc_s;
  logic [AW-1:0]   wr_add_r;
  logic [11:0]     wr_data_r;
  logic            wr_req_r;
  logic            busy_r;
  logic            done_r;
  logic            accept_s;
  logic            s_ready_s;

  assign count_inc_s = count_r + {{(AW-1){1'b0}}, 1'b1};

  // Next-state decode; s_ready depends only on state and abort so it never waits on s_valid.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    s_ready_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (length == {AW{1'b0}}) ? DONE : LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        s_ready_s = ~abort;
        accept_s  = s_valid & ~abort;
        if (abort) begin
          state_next_s = IDLE;
        end else if (accept_s && (count_inc_s == len_r)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = LOAD;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, load parameters and the registered write port; done/busy track the next state
  // so done lands in the same cycle as the final write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      base_r    <= {AW{1'b0}};
      len_r     <= {AW{1'b0}};
      count_r   <= {AW{1'b0}};
      wr_add_r  <= {AW{1'b0}};
      wr_data_r <= 12'h000;
      wr_req_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s == LOAD);
      done_r   <= (state_next_s == DONE);
      wr_req_r <= accept_s;
      if ((state_r == IDLE) && start) begin
        base_r  <= base_addr;
        len_r   <= length;
        count_r <= {AW{1'b0}};
      end
      if (accept_s) begin
        wr_add_r  <= base_r + count_r;
        wr_data_r <= s_data;
        count_r   <= count_inc_s;
      end
    end
  end

  assign s_ready = s_ready_s;
  assign wr_add  = wr_add_r;
  assign wr_data = wr_data_r;
  assign wr_req  = wr_req_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign count   = count_r;

endmodule
